// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   Sequencer and round-key cache for the AES-256 key expander. A start pulse walks the
//   expander through round indices 0..NUM_RK-1. The expander enable stays high for the whole
//   handshake of every round. Each returned round key is captured into a local buffer. Once all
//   keys are cached, the buffer serves single-cycle-latency reads to the cipher datapath.
//
//   Optional feature: define KS_ZEROIZE_EN to clear the buffer (one entry per cycle) after
//   reset, before every expansion, and before settling in the error state.
//
// Ports
//   clk_g         clock (gated upstream)
//   rst_n         asynchronous active-low reset
//   start_i       one-cycle pulse, begin a new expansion (ignored while busy_o)
//   ks_en_o       expander enable
//   ks_round_o    round index driven to the expander
//   ks_ready_i    expander ready pulse; ks_key_i is valid on the following cycle
//   ks_key_i      expander round-key output
//   rk_req_i      round-key read request
//   rk_idx_i      round-key index to read
//   rk_valid_o    read data valid (one cycle after rk_req_i)
//   rk_o          read data (zero on a miss, held when idle)
//   rk_miss_o     one-cycle pulse, request could not be served
//   keys_valid_o  all NUM_RK keys cached
//   busy_o        expansion in progress
//   err_o         sticky expander timeout
module aes_key_sched_ctrl #(
  parameter int unsigned NUM_RK  = 15,
  parameter int unsigned KW      = 128,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk_g,
  input  logic          rst_n,
  input  logic          start_i,
  output logic          ks_en_o,
  output logic [3:0]    ks_round_o,
  input  logic          ks_ready_i,
  input  logic [KW-1:0] ks_key_i,
  input  logic          rk_req_i,
  input  logic [3:0]    rk_idx_i,
  output logic          rk_valid_o,
  output logic [KW-1:0] rk_o,
  output logic          rk_miss_o,
  output logic          keys_valid_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam int unsigned WaitW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0] LastRk = 4'(NUM_RK - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StCapture, StDone, StErr, StZero
  } state_e;

  state_e           state_q;
  logic [3:0]       round_q;
  logic [WaitW-1:0] wait_q;
  logic [KW-1:0]    buffer [NUM_RK];
  logic             rd_hit;

`ifdef KS_ZEROIZE_EN
  logic [3:0] zero_q;
  state_e     ret_q;  // where ZERO goes once the last entry is cleared
`endif

  assign ks_round_o = round_q;

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
`ifdef KS_ZEROIZE_EN
      state_q <= StZero;
      zero_q  <= '0;
      ret_q   <= StIdle;
`else
      state_q <= StIdle;
`endif
      round_q      <= '0;
      wait_q       <= '0;
      ks_en_o      <= 1'b0;
      busy_o       <= 1'b0;
      keys_valid_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start_i) begin
            keys_valid_o <= 1'b0;
            err_o        <= 1'b0;
            round_q      <= '0;
            busy_o       <= 1'b1;
`ifdef KS_ZEROIZE_EN
            state_q <= StZero;
            zero_q  <= '0;
            ret_q   <= StIssue;
`else
            state_q <= StIssue;
            ks_en_o <= 1'b1;
`endif
          end
        end
        StIssue: begin
          wait_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (ks_ready_i) begin
            state_q <= StCapture;
          end else if (wait_q == WaitLast) begin
            ks_en_o <= 1'b0;
`ifdef KS_ZEROIZE_EN
            state_q <= StZero;
            zero_q  <= '0;
            ret_q   <= StErr;
`else
            state_q <= StErr;
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
`endif
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StCapture: begin
          if (round_q == LastRk) begin
            state_q      <= StDone;
            keys_valid_o <= 1'b1;
            busy_o       <= 1'b0;
            ks_en_o      <= 1'b0;
          end else begin
            // Enable stays high across the round boundary
            round_q <= round_q + 4'd1;
            state_q <= StIssue;
          end
        end
`ifdef KS_ZEROIZE_EN
        StZero: begin
          if (zero_q == LastRk) begin
            state_q <= ret_q;
            if (ret_q == StIssue) begin
              ks_en_o <= 1'b1;
            end else begin
              busy_o <= 1'b0;
              err_o  <= (ret_q == StErr);
            end
          end else begin
            zero_q <= zero_q + 4'd1;
            busy_o <= 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  // Key storage carries no reset; contents are only trusted once keys_valid_o is set
  always_ff @(posedge clk_g) begin
    if (state_q == StCapture) begin
      buffer[round_q] <= ks_key_i;
`ifdef KS_ZEROIZE_EN
    end else if (state_q == StZero) begin
      buffer[zero_q] <= '0;
`endif
    end
  end

  // Read port, independent of the sequencer
  assign rd_hit = rk_req_i && keys_valid_o && (rk_idx_i <= LastRk);

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid_o <= 1'b0;
      rk_miss_o  <= 1'b0;
      rk_o       <= '0;
    end else begin
      rk_valid_o <= rd_hit;
      rk_miss_o  <= rk_req_i && !rd_hit;
      if (rd_hit) begin
        rk_o <= buffer[rk_idx_i];
      end else if (rk_req_i) begin
        rk_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl
//   Directed bench for aes_key_sched_ctrl. Acts as the key expander (ready on the third WAIT
//   cycle, key = {4{32'hA5A5_0000 + round}} in the capture cycle) and checks the sequencer,
//   cache reads, misses, timeout, ignored start and mid-expansion reset. Inputs change and
//   outputs are sampled on the falling clock edge.
module tb_aes_key_sched_ctrl;

  localparam int unsigned NUM_RK  = 15;
  localparam int unsigned KW      = 128;
  localparam int unsigned TIMEOUT = 64;

  logic          clk_g = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          ks_ready_i = 1'b0;
  logic [KW-1:0] ks_key_i = '0;
  logic          rk_req_i = 1'b0;
  logic [3:0]    rk_idx_i = 4'd0;
  logic          ks_en_o;
  logic [3:0]    ks_round_o;
  logic          rk_valid_o;
  logic [KW-1:0] rk_o;
  logic          rk_miss_o;
  logic          keys_valid_o;
  logic          busy_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_g = ~clk_g;

  aes_key_sched_ctrl #(
    .NUM_RK  (NUM_RK),
    .KW      (KW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_g        (clk_g),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .ks_en_o      (ks_en_o),
    .ks_round_o   (ks_round_o),
    .ks_ready_i   (ks_ready_i),
    .ks_key_i     (ks_key_i),
    .rk_req_i     (rk_req_i),
    .rk_idx_i     (rk_idx_i),
    .rk_valid_o   (rk_valid_o),
    .rk_o         (rk_o),
    .rk_miss_o    (rk_miss_o),
    .keys_valid_o (keys_valid_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  function automatic logic [KW-1:0] pat(input int r);
    logic [31:0] w;
    w = 32'hA5A5_0000 + 32'(r);
    return {4{w}};
  endfunction

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, KW'(obs), KW'(exp));
  endtask

  task automatic wait_post_reset();
`ifdef KS_ZEROIZE_EN
    repeat (NUM_RK + 1) @(negedge clk_g);
`endif
  endtask

  // One expansion driven from a negedge with the DUT in IDLE/DONE/ERR.
  // hang_rd: ready never comes; poke_rd: start pulsed in ISSUE; rst_rd: reset in WAIT;
  // rd_start: read idx 3 in the same cycle as start.
  task automatic expand(input int hang_rd, input int poke_rd, input int rst_rd,
                        input bit rd_start);
    start_i = 1'b1;
    if (rd_start) begin
      rk_req_i = 1'b1;
      rk_idx_i = 4'd3;
    end
    @(negedge clk_g);
    start_i = 1'b0;
    if (rd_start) begin
      rk_req_i = 1'b0;
      chk1("rd_with_start_valid", rk_valid_o, 1'b1);
      chk("rd_with_start_data", rk_o, pat(3));
      chk1("rd_with_start_kv_drop", keys_valid_o, 1'b0);
    end
`ifdef KS_ZEROIZE_EN
    for (int z = 0; z < int'(NUM_RK); z++) begin
      chk1("zero_en", ks_en_o, 1'b0);
      chk1("zero_busy", busy_o, 1'b1);
      @(negedge clk_g);
    end
`endif
    for (int r = 0; r < int'(NUM_RK); r++) begin
      ks_key_i = ~pat(r);
      chk1("issue_en", ks_en_o, 1'b1);
      chk("issue_round", KW'(ks_round_o), KW'(r));
      chk1("issue_busy", busy_o, 1'b1);
      chk1("issue_kv", keys_valid_o, 1'b0);
      if (r == poke_rd) start_i = 1'b1;
      @(negedge clk_g);
      start_i = 1'b0;
      if (r == hang_rd) begin
        for (int w = 0; w < int'(TIMEOUT); w++) begin
          chk1("hang_wait_en", ks_en_o, 1'b1);
          chk1("hang_wait_err", err_o, 1'b0);
          @(negedge clk_g);
        end
`ifdef KS_ZEROIZE_EN
        for (int z = 0; z < int'(NUM_RK); z++) begin
          chk1("tmo_zero_en", ks_en_o, 1'b0);
          chk1("tmo_zero_err", err_o, 1'b0);
          @(negedge clk_g);
        end
`endif
        chk1("tmo_err", err_o, 1'b1);
        chk1("tmo_en", ks_en_o, 1'b0);
        chk1("tmo_busy", busy_o, 1'b0);
        chk1("tmo_kv", keys_valid_o, 1'b0);
        return;
      end
      for (int w = 0; w < 3; w++) begin
        chk1("wait_en", ks_en_o, 1'b1);
        chk("wait_round", KW'(ks_round_o), KW'(r));
        if (r == rst_rd && w == 1) begin
          rst_n = 1'b0;
          #1;
          chk1("rst_async_en", ks_en_o, 1'b0);
          chk1("rst_async_busy", busy_o, 1'b0);
          @(negedge clk_g);
          rst_n = 1'b1;
          wait_post_reset();
          return;
        end
        if (w == 2) ks_ready_i = 1'b1;
        @(negedge clk_g);
      end
      ks_ready_i = 1'b0;
      ks_key_i   = pat(r);
      chk1("cap_en", ks_en_o, 1'b1);
      chk("cap_round", KW'(ks_round_o), KW'(r));
      chk1("cap_kv", keys_valid_o, 1'b0);
      @(negedge clk_g);
    end
    ks_key_i = '0;
    chk1("done_kv", keys_valid_o, 1'b1);
    chk1("done_busy", busy_o, 1'b0);
    chk1("done_en", ks_en_o, 1'b0);
    chk1("done_err", err_o, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_g);
    chk1("rst_en", ks_en_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_kv", keys_valid_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_valid", rk_valid_o, 1'b0);
    chk1("rst_miss", rk_miss_o, 1'b0);
    chk("rst_rk", rk_o, '0);
    chk("rst_round", KW'(ks_round_o), '0);
    rst_n = 1'b1;
    wait_post_reset();

    // Read before any keys are cached
    rk_req_i = 1'b1;
    rk_idx_i = 4'd0;
    @(negedge clk_g);
    rk_req_i = 1'b0;
    chk1("idle_rd_miss", rk_miss_o, 1'b1);
    chk1("idle_rd_valid", rk_valid_o, 1'b0);

    // Full expansion, then read back every key back-to-back
    expand(-1, -1, -1, 1'b0);
    for (int i = 0; i < int'(NUM_RK); i++) begin
      rk_req_i = 1'b1;
      rk_idx_i = 4'(i);
      @(negedge clk_g);
      chk1("rd_valid", rk_valid_o, 1'b1);
      chk("rd_data", rk_o, pat(i));
      chk1("rd_nomiss", rk_miss_o, 1'b0);
    end
    rk_req_i = 1'b0;
    @(negedge clk_g);
    chk1("rd_idle_valid", rk_valid_o, 1'b0);
    chk("rd_idle_hold", rk_o, pat(14));

    // Out-of-range index, then the last valid index
    rk_req_i = 1'b1;
    rk_idx_i = 4'd15;
    @(negedge clk_g);
    chk1("idx15_miss", rk_miss_o, 1'b1);
    chk1("idx15_valid", rk_valid_o, 1'b0);
    chk("idx15_rk", rk_o, '0);
    rk_idx_i = 4'd14;
    @(negedge clk_g);
    rk_req_i = 1'b0;
    chk1("idx14_miss", rk_miss_o, 1'b0);
    chk1("idx14_valid", rk_valid_o, 1'b1);
    chk("idx14_data", rk_o, pat(14));

    // Read together with start in DONE; start poked at round 7 must be ignored
    expand(-1, 7, -1, 1'b1);

    // Expander hangs at round 4
    expand(4, -1, -1, 1'b0);
    rk_req_i = 1'b1;
    rk_idx_i = 4'd2;
    @(negedge clk_g);
    rk_req_i = 1'b0;
    chk1("err_rd_miss", rk_miss_o, 1'b1);
    chk1("err_rd_valid", rk_valid_o, 1'b0);
    chk1("err_sticky", err_o, 1'b1);
`ifdef KS_ZEROIZE_EN
    for (int i = 0; i < int'(NUM_RK); i++) chk("zeroized_entry", dut.buffer[i], '0);
`endif

    // Reset during round 9 WAIT, then a clean restart
    expand(-1, -1, 9, 1'b0);
    chk1("post_rst_en", ks_en_o, 1'b0);
    chk1("post_rst_busy", busy_o, 1'b0);
    chk1("post_rst_kv", keys_valid_o, 1'b0);
    chk1("post_rst_err", err_o, 1'b0);
    chk("post_rst_round", KW'(ks_round_o), '0);
    expand(-1, -1, -1, 1'b0);
    rk_req_i = 1'b1;
    rk_idx_i = 4'd9;
    @(negedge clk_g);
    rk_idx_i = 4'd0;
    chk1("restart_rd9_valid", rk_valid_o, 1'b1);
    chk("restart_rd9_data", rk_o, pat(9));
    @(negedge clk_g);
    rk_req_i = 1'b0;
    chk("restart_rd0_data", rk_o, pat(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
